// File: rtl/serial_shift_out.sv
// Serialises a WIDTH-bit word onto s_clk/s_out for LED / 7-segment shift-register chains,
// then latches it with a rising edge on s_pen; start/busy/done handshake, optional auto-refresh.
module serial_shift_out #(
  parameter int WIDTH     = 16,
  parameter int HALF      = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit INVERT    = 1'b0,
  parameter bit AUTO      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pdata,
  output logic             busy,
  output logic             done,
  output logic             s_clk,
  output logic             s_out,
  output logic             s_pen,
  output logic             s_clrn
);

  localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {CLEAR, IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [DW-1:0]    div;
  logic [CW-1:0]    bitcnt;

  logic [WIDTH-1:0] frame;
  logic [WIDTH-1:0] shadow_next;
  logic             first_bit;
  logic             next_bit;
  logic             go;
  logic             div_end;

  assign frame       = INVERT ? ~pdata : pdata;
  assign first_bit   = MSB_FIRST ? frame[WIDTH-1] : frame[0];
  assign shadow_next = MSB_FIRST ? {shadow[WIDTH-2:0], 1'b0} : {1'b0, shadow[WIDTH-1:1]};
  // Bit that becomes the head of the shadow register after the next shift.
  assign next_bit    = MSB_FIRST ? shadow[WIDTH-2] : shadow[1];
  assign go          = start | AUTO;
  assign div_end     = (div == DW'(HALF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      shadow <= '0;
      div    <= '0;
      bitcnt <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      s_clk  <= 1'b0;
      s_out  <= 1'b0;
      s_pen  <= 1'b0;
      s_clrn <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        CLEAR: begin
          if (div_end) begin
            div    <= '0;
            state  <= IDLE;
            busy   <= 1'b0;
            s_clrn <= 1'b1;
            s_pen  <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        IDLE: begin
          if (go) begin
            shadow <= frame;
            bitcnt <= CW'(WIDTH - 1);
            div    <= '0;
            state  <= SHIFT_LO;
            busy   <= 1'b1;
            s_pen  <= 1'b0;
            s_clk  <= 1'b0;
            s_out  <= first_bit;
          end
        end
        SHIFT_LO: begin
          if (div_end) begin
            div   <= '0;
            state <= SHIFT_HI;
            s_clk <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div_end) begin
            div   <= '0;
            s_clk <= 1'b0;
            if (bitcnt == '0) begin
              state <= LATCH;
            end else begin
              bitcnt <= bitcnt - 1'b1;
              shadow <= shadow_next;
              s_out  <= next_bit;
              state  <= SHIFT_LO;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        LATCH: begin
          if (div_end) begin
            div   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s_pen <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_out.sv
// Directed bench for serial_shift_out: five instances cover MSB/LSB order, inversion,
// auto-refresh and the minimum WIDTH=2/HALF=1 configuration.
module tb_serial_shift_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start16 = 1'b0;
  logic [15:0] pdata_a = '0;
  logic [15:0] pdata_b = '0;
  logic        start4  = 1'b0;
  logic [1:0]  pdata4  = '0;
  logic [7:0]  pdata3  = 8'h81;

  logic busy0, done0, sclk0, sout0, spen0, sclrn0;
  logic busy1, done1, sclk1, sout1, spen1, sclrn1;
  logic busy2, done2, sclk2, sout2, spen2, sclrn2;
  logic busy3, done3, sclk3, sout3, spen3, sclrn3;
  logic busy4, done4, sclk4, sout4, spen4, sclrn4;

  serial_shift_out #(.WIDTH(16), .HALF(2)) u0 (
    .clk(clk), .rst(rst), .start(start16), .pdata(pdata_a), .busy(busy0), .done(done0),
    .s_clk(sclk0), .s_out(sout0), .s_pen(spen0), .s_clrn(sclrn0));
  serial_shift_out #(.WIDTH(16), .HALF(2), .INVERT(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start16), .pdata(pdata_a), .busy(busy1), .done(done1),
    .s_clk(sclk1), .s_out(sout1), .s_pen(spen1), .s_clrn(sclrn1));
  serial_shift_out #(.WIDTH(16), .HALF(2), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start16), .pdata(pdata_b), .busy(busy2), .done(done2),
    .s_clk(sclk2), .s_out(sout2), .s_pen(spen2), .s_clrn(sclrn2));
  serial_shift_out #(.WIDTH(8), .HALF(1), .AUTO(1'b1)) u3 (
    .clk(clk), .rst(rst), .start(1'b0), .pdata(pdata3), .busy(busy3), .done(done3),
    .s_clk(sclk3), .s_out(sout3), .s_pen(spen3), .s_clrn(sclrn3));
  serial_shift_out #(.WIDTH(2), .HALF(1)) u4 (
    .clk(clk), .rst(rst), .start(start4), .pdata(pdata4), .busy(busy4), .done(done4),
    .s_clk(sclk4), .s_out(sout4), .s_pen(spen4), .s_clrn(sclrn4));

  // Serial capture: cumulative edge counts and a shift register of sampled bits per instance.
  int e0 = 0, e1 = 0, e2 = 0, e3 = 0, e4 = 0;
  logic [15:0] w0 = '0, w1 = '0, w2 = '0;
  logic [7:0]  w3 = '0;
  logic [1:0]  w4 = '0;
  int d0 = 0;
  always @(posedge sclk0) begin e0 = e0 + 1; w0 = {w0[14:0], sout0}; end
  always @(posedge sclk1) begin e1 = e1 + 1; w1 = {w1[14:0], sout1}; end
  always @(posedge sclk2) begin e2 = e2 + 1; w2 = {w2[14:0], sout2}; end
  always @(posedge sclk3) begin e3 = e3 + 1; w3 = {w3[6:0], sout3}; end
  always @(posedge sclk4) begin e4 = e4 + 1; w4 = {w4[0], sout4}; end
  always @(negedge clk) if (done0) d0 = d0 + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int n, b, base0, base1, base2, base3, base4, dbase;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy0}, 32'd1);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_sclk", {31'd0, sclk0}, 32'd0);
    chk("rst_sout", {31'd0, sout0}, 32'd0);
    chk("rst_spen", {31'd0, spen0}, 32'd0);
    chk("rst_sclrn", {31'd0, sclrn0}, 32'd0);

    // CLEAR lasts HALF=2 cycles after release
    rst = 1'b0;
    @(negedge clk);
    chk("clr_hold", {31'd0, sclrn0}, 32'd0);
    @(negedge clk);
    chk("clr_exit_sclrn", {31'd0, sclrn0}, 32'd1);
    chk("clr_exit_spen", {31'd0, spen0}, 32'd1);
    chk("clr_exit_busy", {31'd0, busy0}, 32'd0);
    chk("clr_exit_nodone", {31'd0, done0}, 32'd0);

    // Frame A5C3 with ignored starts at busy cycles 5 and 30
    @(negedge clk);
    base0 = e0; base1 = e1; base2 = e2; dbase = d0;
    pdata_a = 16'hA5C3; pdata_b = 16'h0001; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (busy0 && n < 1000) begin
      n++;
      start16 = (n == 5 || n == 30);
      @(negedge clk);
    end
    start16 = 1'b0;
    chk("f1_busy_cycles", n, 66);
    chk("f1_done", {31'd0, done0}, 32'd1);
    chk("f1_spen_rise", {31'd0, spen0}, 32'd1);
    chk("f1_word", {16'd0, w0}, 32'h0000A5C3);
    chk("f1_edges", e0 - base0, 16);
    chk("inv_word", {16'd0, w1}, 32'h00005A3C);
    chk("inv_edges", e1 - base1, 16);
    chk("lsb_word", {16'd0, w2}, 32'h00008000);
    chk("lsb_edges", e2 - base2, 16);
    @(negedge clk);
    chk("f1_done_pulse", {31'd0, done0}, 32'd0);
    @(negedge clk);
    chk("f1_no_queue", {31'd0, busy0}, 32'd0);
    chk("f1_done_count", d0 - dbase, 1);

    // start held through done; pdata changed mid-frame must not disturb the frame
    pdata_a = 16'h1234; start16 = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy0 && n < 1000) begin
      n++;
      if (n == 10) pdata_a = 16'h00FF;
      @(negedge clk);
    end
    chk("f2_busy_cycles", n, 66);
    chk("f2_done", {31'd0, done0}, 32'd1);
    chk("f2_word", {16'd0, w0}, 32'h00001234);
    base0 = e0;
    @(negedge clk);
    start16 = 1'b0;
    chk("f3_no_gap", {31'd0, busy0}, 32'd1);

    // Asynchronous reset mid-frame at bit 7
    n = 0;
    while ((e0 - base0) < 7 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("f3_reach_bit7", e0 - base0, 7);
    dbase = d0;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy0}, 32'd1);
    chk("arst_sclk", {31'd0, sclk0}, 32'd0);
    chk("arst_sout", {31'd0, sout0}, 32'd0);
    chk("arst_spen", {31'd0, spen0}, 32'd0);
    chk("arst_sclrn", {31'd0, sclrn0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_clr_hold", {31'd0, sclrn0}, 32'd0);
    @(negedge clk);
    chk("arst_clr_exit", {31'd0, sclrn0}, 32'd1);
    chk("arst_idle_spen", {31'd0, spen0}, 32'd1);
    chk("arst_idle_busy", {31'd0, busy0}, 32'd0);
    chk("arst_no_done", d0 - dbase, 0);

    // AUTO: back-to-back 8'h81 frames, done every 18 cycles
    n = 0;
    while (!done3 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("auto_first_done", {31'd0, done3}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      base3 = e3; n = 0; b = 0;
      do begin
        @(negedge clk);
        n++;
        if (busy3) b++;
      end while (!done3 && n < 100);
      chk("auto_period", n, 18);
      chk("auto_busy", b, 17);
      chk("auto_edges", e3 - base3, 8);
      chk("auto_word", {24'd0, w3}, 32'h00000081);
    end

    // WIDTH=2, HALF=1 boundary: two consecutive frames
    chk("w2_idle", {31'd0, busy4}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      base4 = e4;
      pdata4 = (k == 0) ? 2'b10 : 2'b01;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (busy4 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("w2_busy_cycles", n, 5);
      chk("w2_done", {31'd0, done4}, 32'd1);
      chk("w2_edges", e4 - base4, 2);
      chk("w2_word", {30'd0, w4}, (k == 0) ? 32'd2 : 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
